// File: rtl/countdown_timer.sv
// Loadable down-counting interval timer with one-shot and periodic modes.
// Pulses done on terminal count, then either expires or reloads the start value.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state;
  logic [WIDTH-1:0] reload_reg;

  // Reset beats load, and load beats counting in every state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      value      <= ZERO;
      reload_reg <= ZERO;
      done       <= 1'b0;
    end else if (load) begin
      value      <= load_value;
      reload_reg <= load_value;
      done       <= 1'b0;
      state      <= (load_value != ZERO) ? ST_RUN : ST_IDLE;
    end else begin
      done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (enable) begin
            if (value > ONE) begin
              value <= value - ONE;
            end else if (value == ONE) begin
              done <= 1'b1;
              if (auto_reload) begin
                value <= reload_reg;
              end else begin
                value <= ZERO;
                state <= ST_EXPIRED;
              end
            end
          end
        end
        ST_EXPIRED: value <= ZERO;
        default: ;
      endcase
    end
  end

  assign busy    = (state == ST_RUN);
  assign expired = (state == ST_EXPIRED);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios plus random traffic,
// checked against a remaining-ticks model of the timer.
module tb_countdown_timer;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] load_value;
  logic       enable;
  logic       auto_reload;
  logic [7:0] value;
  logic       busy;
  logic       done;
  logic       expired;

  typedef struct {
    int value;
    bit busy;
    bit done;
    bit expired;
  } expect_t;

  expect_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  // Reference model: ticks left until terminal count, the period, and the mode.
  int  m_left    = 0;
  int  m_period  = 0;
  bit  m_running = 0;
  bit  m_over    = 0;
  bit  m_done    = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_value(load_value),
    .enable(enable),
    .auto_reload(auto_reload),
    .value(value),
    .busy(busy),
    .done(done),
    .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance the model by one clock edge under the given inputs.
  task automatic modelEdge(input bit r, input bit ld, input int lv, input bit en, input bit ar);
    m_done = 0;
    if (r) begin
      m_left = 0; m_period = 0; m_running = 0; m_over = 0;
    end else if (ld) begin
      m_left = lv; m_period = lv; m_running = (lv != 0); m_over = 0;
    end else if (m_running && en) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_done = 1;
        if (ar) m_left = m_period;
        else begin
          m_running = 0;
          m_over = 1;
        end
      end
    end
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic applyStimulus(input bit r, input bit ld, input int lv, input bit en, input bit ar);
    expect_t e;
    @(negedge clk);
    reset       = r;
    load        = ld;
    load_value  = lv[7:0];
    enable      = en;
    auto_reload = ar;
    @(posedge clk);
    modelEdge(r, ld, lv, en, ar);
    e.value   = m_left;
    e.busy    = m_running;
    e.done    = m_done;
    e.expired = m_over;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    checks++;
    if (int'(value) != e.value) begin
      failures++;
      $display("[TB] FAIL value at %0t: got %0d expected %0d", $time, value, e.value);
    end
    checks++;
    if (busy != e.busy) begin
      failures++;
      $display("[TB] FAIL busy at %0t: got %0b expected %0b", $time, busy, e.busy);
    end
    checks++;
    if (done != e.done) begin
      failures++;
      $display("[TB] FAIL done at %0t: got %0b expected %0b", $time, done, e.done);
    end
    checks++;
    if (expired != e.expired) begin
      failures++;
      $display("[TB] FAIL expired at %0t: got %0b expected %0b", $time, expired, e.expired);
    end
  endtask

  // Monitor: the timer presents a result after every edge, so compare each negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        expect_t e;
        e = exp_q.pop_front();
        if (done === 1'b1) done_seen++;
        checkOutput(e);
      end
    end
  end

  task automatic checkDoneCount(input string name, input int want);
    checks++;
    if (done_seen != want) begin
      failures++;
      $display("[TB] FAIL %s: got %0d done pulses expected %0d", name, done_seen, want);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; auto_reload = 1'b0;

    $display("[TB] reset");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0);

    $display("[TB] one-shot load 5");
    settle(); done_seen = 0;
    applyStimulus(0, 1, 5, 1, 0);
    for (int i = 0; i < 15; i++) applyStimulus(0, 0, 0, 1, 0);
    settle(); checkDoneCount("oneshot5", 1);

    $display("[TB] periodic load 3");
    done_seen = 0;
    applyStimulus(0, 1, 3, 1, 1);
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 1, 1);
    settle(); checkDoneCount("periodic3", 4);

    $display("[TB] gated enable load 4");
    done_seen = 0;
    applyStimulus(0, 1, 4, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, (i % 2) == 0, 0);
    settle(); checkDoneCount("gated4", 1);

    $display("[TB] load over terminal, then reset");
    done_seen = 0;
    applyStimulus(0, 1, 2, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 200, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    settle(); checkDoneCount("loadwins", 0);

    $display("[TB] load 0 then load 255");
    done_seen = 0;
    applyStimulus(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 255, 1, 0);
    for (int i = 0; i < 258; i++) applyStimulus(0, 0, 0, 1, 0);
    settle(); checkDoneCount("max255", 1);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      bit r, ld, en, ar;
      int lv;
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 24) == 0);
      lv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 8);
      en = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      applyStimulus(r, ld, lv, en, ar);
    end

    settle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
